data_mem_responder: RTL and testbench

- Memory-side responder for the single-cycle core's data port: accepts addr/wr_en/wdata/wmask and returns rdata combinationally in the same cycle.
- Backs a DEPTH x 64-bit RAM with byte-masked synchronous writes.
- After reset, a zero-fill state machine clears the RAM before accepting traffic.
- Provides a small MMIO window with a 64-bit cycle counter, a tohost/done register and sticky error status; sits between the processor and the testbench top.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/dmem_ram_bytemask.sv | 32 +++
 rtl/data_mem_responder.sv | 143 ++++++++++++++
 tb/tb_data_mem_responder.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

    // MMIO register byte offsets from the window base
    localparam logic [31:0] CYCLE_LO = 32'h0;
    localparam logic [31:0] CYCLE_HI = 32'h4;
    localparam logic [31:0] TOHOST   = 32'h8;
    localparam logic [31:0] STATUS   = 32'hC;

    // Returned for any address outside RAM and the MMIO registers
    localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Core <-> data-memory port: address/write request in, read data and status out.
// Latency: reads are combinational; writes commit at the next rising edge.
// Backpressure: none; busy tells the core that requests are being dropped.
interface data_mem_responder_if;
    logic [31:0] addr;
    logic        wr_en;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic [31:0] tohost;
    logic        err;

    modport master (
        output addr, wr_en, wdata, wmask,
        input  rdata, busy, done, tohost, err
    );

    modport slave (
        input  addr, wr_en, wdata, wmask,
        output rdata, busy, done, tohost, err
    );
endinterface

// File: rtl/dmem_ram_bytemask.sv
// DEPTH x 64-bit RAM, one byte-masked write port and one combinational read port.
// Latency: read 0 cycles; write lands at the rising edge, visible the cycle after.
// Backpressure: none; every enabled write is accepted.
module dmem_ram_bytemask #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [63:0]   i_wdata,
    input  logic [7:0]    i_wmask,
    input  logic [AW-1:0] i_raddr,
    output logic [63:0]   o_rdata
);
    logic [63:0] r_mem [DEPTH];

    // Byte-enabled write; unmasked bytes keep their old contents
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < 8; i++) begin
                if (i_wmask[i]) begin
                    r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read sees pre-edge contents, so there is no write-to-read forwarding
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder: zero-filled RAM plus MMIO cycle counter, tohost/done and error status.
// Latency: rdata combinational; RAM/tohost writes and status flags update at the next edge.
// Backpressure: none; while busy (reset or zero-fill) core writes are dropped and rdata is 0.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                rst,
    data_mem_responder_if.slave bus
);
    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH) << 3;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_fill_idx;
    logic [AW-1:0] w_fill_idx_nxt;
    logic [63:0]   r_cycle;
    logic          r_done;
    logic          r_err;
    logic [31:0]   r_tohost;

    logic          w_ready;
    logic          w_ram_hit;
    logic          w_hit_lo;
    logic          w_hit_hi;
    logic          w_hit_tohost;
    logic          w_hit_status;
    logic          w_mapped;
    logic [AW-1:0] w_word_idx;
    logic [63:0]   w_ram_rdata;
    logic          w_ram_we;
    logic [AW-1:0] w_ram_waddr;
    logic [63:0]   w_ram_wdata;
    logic [7:0]    w_ram_wmask;
    logic [31:0]   w_rdata;

    // Address decode; MMIO registers match their exact byte address
    assign w_ready      = (r_state == READY);
    assign w_ram_hit    = ({1'b0, bus.addr} < RAM_BYTES);
    assign w_hit_lo     = (bus.addr == MMIO_BASE + CYCLE_LO);
    assign w_hit_hi     = (bus.addr == MMIO_BASE + CYCLE_HI);
    assign w_hit_tohost = (bus.addr == MMIO_BASE + TOHOST);
    assign w_hit_status = (bus.addr == MMIO_BASE + STATUS);
    assign w_mapped     = w_ram_hit | w_hit_lo | w_hit_hi | w_hit_tohost | w_hit_status;
    assign w_word_idx   = bus.addr[AW+2:3];

    // Fill-engine state register; reset restarts the fill from index 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= INIT;
            r_fill_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fill_idx <= w_fill_idx_nxt;
        end
    end

    // Next state and RAM write-port mux: fill engine owns the port in INIT, the core in READY
    always_comb begin
        w_state_nxt    = r_state;
        w_fill_idx_nxt = r_fill_idx;
        w_ram_we       = 1'b0;
        w_ram_waddr    = w_word_idx;
        w_ram_wdata    = bus.wdata;
        w_ram_wmask    = bus.wmask;
        case (r_state)
            INIT: begin
                w_ram_we       = 1'b1;
                w_ram_waddr    = r_fill_idx;
                w_ram_wdata    = '0;
                w_ram_wmask    = 8'hFF;
                w_fill_idx_nxt = r_fill_idx + AW'(1);
                if (r_fill_idx == AW'(DEPTH - 1)) begin
                    w_state_nxt = READY;
                end
            end
            READY: begin
                w_ram_we = bus.wr_en & w_ram_hit;
            end
        endcase
    end

    dmem_ram_bytemask #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_wmask (w_ram_wmask),
        .i_raddr (w_word_idx),
        .o_rdata (w_ram_rdata)
    );

    // Cycle counter and sticky status; all frozen while the fill is running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle  <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_tohost <= '0;
        end else if (w_ready) begin
            r_cycle <= r_cycle + 64'd1;
            if (!w_mapped) begin
                r_err <= 1'b1;
            end
            if (w_hit_tohost && bus.wr_en && (|bus.wmask[3:0])) begin
                r_tohost <= bus.wdata[31:0];
                r_done   <= 1'b1;
            end
        end
    end

    // Read mux; every value reflects pre-edge state
    always_comb begin
        w_rdata = UNMAPPED_RDATA;
        if (!w_ready) begin
            w_rdata = '0;
        end else if (w_ram_hit) begin
            w_rdata = bus.addr[2] ? w_ram_rdata[63:32] : w_ram_rdata[31:0];
        end else if (w_hit_lo) begin
            w_rdata = r_cycle[31:0];
        end else if (w_hit_hi) begin
            w_rdata = r_cycle[63:32];
        end else if (w_hit_tohost) begin
            w_rdata = r_tohost;
        end else if (w_hit_status) begin
            w_rdata = {30'b0, r_err, r_done};
        end
    end

    assign bus.rdata  = w_rdata;
    assign bus.busy   = !w_ready;
    assign bus.done   = r_done;
    assign bus.tohost = r_tohost;
    assign bus.err    = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench with a map-based reference model checked on every falling edge.
// Latency: model advances on the same rising edge as the design.
// Backpressure: n/a.
module tb_data_mem_responder;
    localparam int          DEPTH   = 1024;
    localparam logic [31:0] MB      = 32'h8000_0000;
    localparam logic [31:0] RAM_END = 32'(DEPTH * 8);

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    data_mem_responder_if bus();

    data_mem_responder #(
        .DEPTH     (DEPTH),
        .MMIO_BASE (MB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: sparse RAM (missing entry == zero), fill progress, flags
    logic [63:0] m_mem [int];
    logic [63:0] m_cycle  = 64'h0;
    int          m_fill   = 0;
    logic        m_done   = 1'b0;
    logic        m_err    = 1'b0;
    logic [31:0] m_tohost = 32'h0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] m_word(logic [31:0] a);
        int k = int'(a >> 3);
        return m_mem.exists(k) ? m_mem[k] : 64'h0;
    endfunction

    function automatic logic [31:0] exp_rdata(logic [31:0] a);
        logic [63:0] w;
        if (m_fill < DEPTH) return 32'h0;
        if (a < RAM_END) begin
            w = m_word(a);
            return ((a / 4) % 2 == 1) ? w[63:32] : w[31:0];
        end
        if (a == MB)         return m_cycle[31:0];
        if (a == MB + 32'h4) return m_cycle[63:32];
        if (a == MB + 32'h8) return m_tohost;
        if (a == MB + 32'hC) return {30'b0, m_err, m_done};
        return 32'hDEAD_BEEF;
    endfunction

    // Model update on each rising edge (or immediately on reset)
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_mem.delete();
            m_cycle  = 64'h0;
            m_fill   = 0;
            m_done   = 1'b0;
            m_err    = 1'b0;
            m_tohost = 32'h0;
        end else if (m_fill < DEPTH) begin
            m_fill++;
        end else begin
            logic [63:0] w;
            m_cycle = m_cycle + 64'd1;
            if (bus.addr < RAM_END) begin
                if (bus.wr_en) begin
                    w = m_word(bus.addr);
                    for (int b = 0; b < 8; b++)
                        if (bus.wmask[b]) w[8*b +: 8] = bus.wdata[8*b +: 8];
                    m_mem[int'(bus.addr >> 3)] = w;
                end
            end else if (bus.addr == MB + 32'h8) begin
                if (bus.wr_en && bus.wmask[3:0] != 4'h0) begin
                    m_tohost = bus.wdata[31:0];
                    m_done   = 1'b1;
                end
            end else if (bus.addr != MB && bus.addr != MB + 32'h4 && bus.addr != MB + 32'hC) begin
                m_err = 1'b1;
            end
        end
    end

    // Compare process: every falling edge, all outputs against the model
    initial forever begin
        @(negedge clk);
        chk("busy",   64'(bus.busy),   64'(rst || m_fill < DEPTH));
        chk("done",   64'(bus.done),   64'(m_done));
        chk("err",    64'(bus.err),    64'(m_err));
        chk("tohost", 64'(bus.tohost), 64'(m_tohost));
        chk("rdata",  64'(bus.rdata),  64'(exp_rdata(bus.addr)));
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [31:0] a, logic we, logic [63:0] d, logic [7:0] m);
        bus.addr  = a;
        bus.wr_en = we;
        bus.wdata = d;
        bus.wmask = m;
    endtask

    task automatic rd_chk(string name, logic [31:0] a, logic [31:0] exp);
        drive(a, 1'b0, 64'h0, 8'h0);
        @(negedge clk);
        chk(name, 64'(bus.rdata), 64'(exp));
        step();
    endtask

    task automatic wait_ready(string name);
        int n = 0;
        while (bus.busy && n < DEPTH + 8) begin
            step();
            n++;
        end
        chk(name, 64'(n), 64'(DEPTH));
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_busy"},   64'(bus.busy),   64'h1);
        chk({tag, "_done"},   64'(bus.done),   64'h0);
        chk({tag, "_err"},    64'(bus.err),    64'h0);
        chk({tag, "_tohost"}, 64'(bus.tohost), 64'h0);
        chk({tag, "_rdata"},  64'(bus.rdata),  64'h0);
    endtask

    logic [31:0] c0, c1;

    initial begin
        drive(32'h0, 1'b0, 64'h0, 8'h0);
        #1 rst = 1'b1;
        step();
        chk_reset_outputs("rst0");

        // Fill phase: a core write of all-ones to 0x0 must be dropped
        drive(32'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        step();
        rst = 1'b0;
        wait_ready("busy_len_0");
        rd_chk("rd_0",    32'h0,    32'h0);
        rd_chk("rd_1ffc", 32'h1FFC, 32'h0);

        // Byte-masked write; same-cycle read still returns old data
        drive(32'h10, 1'b1, 64'h1122_3344_5566_7788, 8'b1010_0101);
        @(negedge clk);
        chk("wr_same_cycle", 64'(bus.rdata), 64'h0);
        step();
        rd_chk("rd_10", 32'h10, 32'h0066_0088);
        rd_chk("rd_14", 32'h14, 32'h1100_3300);

        // wmask=0 is a no-op
        drive(32'h10, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        step();
        rd_chk("wmask0_10", 32'h10, 32'h0066_0088);
        chk("wmask0_err", 64'(bus.err), 64'h0);

        // Writes to read-only MMIO are ignored and do not flag errors
        drive(MB, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        step();
        drive(MB + 32'hC, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        step();
        chk("ro_wr_err",  64'(bus.err),  64'h0);
        chk("ro_wr_done", 64'(bus.done), 64'h0);

        // Unmapped read
        drive(32'h0000_4000, 1'b0, 64'h0, 8'h0);
        @(negedge clk);
        chk("unm_rdata", 64'(bus.rdata), 64'hDEAD_BEEF);
        chk("unm_err_pre", 64'(bus.err), 64'h0);
        step();
        chk("unm_err_set", 64'(bus.err), 64'h1);
        rd_chk("status_err", MB + 32'hC, 32'h2);
        rd_chk("unm_2000", 32'h2000, 32'hDEAD_BEEF);

        // TOHOST write
        drive(MB + 32'h8, 1'b1, 64'hABCD_0000_0000_0001, 8'h0F);
        step();
        chk("tohost_done", 64'(bus.done),   64'h1);
        chk("tohost_val",  64'(bus.tohost), 64'h1);
        rd_chk("status_both", MB + 32'hC, 32'h3);
        drive(MB + 32'h8, 1'b1, 64'h0000_0000_0000_0055, 8'hF0);
        step();
        chk("tohost_hi_mask", 64'(bus.tohost), 64'h1);
        rd_chk("tohost_rd", MB + 32'h8, 32'h1);

        // Counter advances by one per READY cycle
        drive(MB, 1'b0, 64'h0, 8'h0);
        @(negedge clk);
        c0 = bus.rdata;
        step();
        @(negedge clk);
        c1 = bus.rdata;
        chk("cyc_delta", 64'(c1 - c0), 64'h1);
        step();

        // Counter wrap at 2^64-1
        force dut.r_cycle = 64'hFFFF_FFFF_FFFF_FFFF;
        m_cycle = 64'hFFFF_FFFF_FFFF_FFFF;
        drive(MB, 1'b0, 64'h0, 8'h0);
        @(negedge clk);
        chk("cyc_lo_max", 64'(bus.rdata), 64'hFFFF_FFFF);
        #2 release dut.r_cycle;
        step();
        @(negedge clk);
        chk("cyc_lo_wrap", 64'(bus.rdata), 64'h0);
        step();
        rd_chk("cyc_hi_wrap", MB + 32'h4, 32'h0);

        // Reset mid-READY: immediate async clear, fill restarts, old data gone
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_ready");
        step();
        step();
        rst = 1'b0;
        wait_ready("busy_len_1");
        rd_chk("post_rst_10", 32'h10, 32'h0);
        rd_chk("post_rst_14", 32'h14, 32'h0);
        rd_chk("post_rst_status", MB + 32'hC, 32'h0);

        // Reset mid-INIT at fill index 500
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (500) step();
        chk("mid_init_busy", 64'(bus.busy), 64'h1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_init");
        step();
        rst = 1'b0;
        wait_ready("busy_len_2");
        rd_chk("post_init_rd", 32'h10, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
